// File: rtl/softmax_sequencer_if.sv
// Control/status bundle between a softmax sequencer and whatever drives it.
// The master side issues row requests and stalls; the slave side is the sequencer.
interface softmax_sequencer_if #(
  parameter int ROW_LEN_WIDTH = 8
);
  logic                     start;
  logic [ROW_LEN_WIDTH-1:0] row_len;
  logic                     hold;
  logic [2:0]               op_code;
  logic                     op_valid;
  logic [ROW_LEN_WIDTH-1:0] elem_idx;
  logic [2:0]               phase;
  logic                     busy;
  logic                     done;

  modport master (
    output start, row_len, hold,
    input  op_code, op_valid, elem_idx, phase, busy, done
  );

  modport slave (
    input  start, row_len, hold,
    output op_code, op_valid, elem_idx, phase, busy, done
  );
endinterface

// File: rtl/softmax_sequencer.sv
// Steps one PE through a softmax row: MAX, EXP, SUM, DIV over N elements,
// with idle gaps between phases so the PE pipeline can drain.
module softmax_sequencer #(
  parameter int ROW_LEN_WIDTH = 8,
  parameter int GAP_CYCLES    = 2
) (
  input logic              clk,
  input logic              reset,
  softmax_sequencer_if.slave sif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAX  = 3'd1,
    GAP  = 3'd2,
    EXP  = 3'd3,
    SUM  = 3'd4,
    DIV  = 3'd5,
    DONE = 3'd6
  } phase_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [2:0] OP_MAX = 3'b000;
  localparam logic [2:0] OP_EXP = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_NOP = 3'b100;

  phase_t                   phase_reg, phase_next;
  phase_t                   ret_reg, ret_next;
  logic [ROW_LEN_WIDTH-1:0] elem_reg, elem_next;
  logic [ROW_LEN_WIDTH-1:0] n_reg, n_next;
  logic [GAP_W-1:0]         gap_reg, gap_next;

  logic [ROW_LEN_WIDTH-1:0] n_last;
  logic                     op_phase;
  logic                     last_elem;

  function automatic phase_t following_op(input phase_t p);
    case (p)
      MAX:     following_op = EXP;
      EXP:     following_op = SUM;
      SUM:     following_op = DIV;
      default: following_op = DONE;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg <= IDLE;
      ret_reg   <= IDLE;
      elem_reg  <= '0;
      n_reg     <= '0;
      gap_reg   <= '0;
    end else begin
      phase_reg <= phase_next;
      ret_reg   <= ret_next;
      elem_reg  <= elem_next;
      n_reg     <= n_next;
      gap_reg   <= gap_next;
    end
  end

  // Full-width compare so N = 2^W-1 ends at index 2^W-2 without wrapping.
  assign n_last    = n_reg - 1'b1;
  assign last_elem = (elem_reg == n_last);
  assign op_phase  = (phase_reg == MAX) || (phase_reg == EXP) ||
                     (phase_reg == SUM) || (phase_reg == DIV);

  always_comb begin
    phase_next = phase_reg;
    ret_next   = ret_reg;
    elem_next  = elem_reg;
    n_next     = n_reg;
    gap_next   = gap_reg;
    case (phase_reg)
      IDLE: begin
        elem_next = '0;
        if (sif.start) begin
          n_next     = sif.row_len;
          phase_next = (sif.row_len == '0) ? DONE : MAX;
        end
      end
      MAX, EXP, SUM, DIV: begin
        if (!sif.hold) begin
          if (last_elem) begin
            elem_next = '0;
            if (phase_reg == DIV) begin
              phase_next = DONE;
            end else if (GAP_CYCLES == 0) begin
              phase_next = following_op(phase_reg);
            end else begin
              phase_next = GAP;
              ret_next   = following_op(phase_reg);
              gap_next   = '0;
            end
          end else begin
            elem_next = elem_reg + 1'b1;
          end
        end
      end
      GAP: begin
        elem_next = '0;
        if (!sif.hold) begin
          if (gap_reg == GAP_LAST) begin
            phase_next = ret_reg;
            gap_next   = '0;
          end else begin
            gap_next = gap_reg + 1'b1;
          end
        end
      end
      DONE: begin
        elem_next  = '0;
        phase_next = IDLE;
      end
      default: begin
        elem_next  = '0;
        phase_next = IDLE;
      end
    endcase
  end

  always_comb begin
    sif.op_valid = op_phase && !sif.hold;
    sif.op_code  = OP_NOP;
    if (sif.op_valid) begin
      case (phase_reg)
        MAX:     sif.op_code = OP_MAX;
        EXP:     sif.op_code = OP_EXP;
        SUM:     sif.op_code = OP_ADD;
        DIV:     sif.op_code = OP_DIV;
        default: sif.op_code = OP_NOP;
      endcase
    end
  end

  assign sif.elem_idx = elem_reg;
  assign sif.phase    = phase_reg;
  assign sif.busy     = (phase_reg != IDLE);
  assign sif.done     = (phase_reg == DONE);

endmodule
